// File: rtl/sar_adc_if.sv
// sar_adc_if - signal bundle between a conversion requester and the SAR ADC model.
//
// Parameters:
//   NBITS  output code width (must match the sar_adc instance)
//
// Signals:
//   en     conversion request tick              (master -> slave)
//   A_in   real-valued analog input in volts    (master -> slave)
//   D_out  last completed conversion code       (slave -> master)
//   valid  one-cycle strobe, D_out just updated (slave -> master)
//   busy   conversion in progress               (slave -> master)
//   ovr    sticky overrun flag                  (slave -> master)
interface sar_adc_if #(
   parameter int NBITS = 8
);
   logic             en;
   real              A_in;
   logic [NBITS-1:0] D_out;
   logic             valid;
   logic             busy;
   logic             ovr;

   modport master (
      output en,
      output A_in,
      input  D_out,
      input  valid,
      input  busy,
      input  ovr
   );

   modport slave (
      input  en,
      input  A_in,
      output D_out,
      output valid,
      output busy,
      output ovr
   );
endinterface

// File: rtl/sar_adc.sv
// sar_adc - behavioural successive-approximation ADC, receiving side of the
// sine-wave DAC loopback.
//
// On an accepted en tick the analog input is captured into a hold register and
// resolved MSB-first, one bit per clock, against a VREF full scale. The final
// code appears on D_out together with a one-cycle valid strobe.
//
// Parameters:
//   VREF   full-scale reference voltage (real, volts), default 3.3
//   NBITS  output code width, legal range 2..16, default 8
//
// Ports:
//   clk    system clock, rising edge active
//   rst_n  asynchronous active-low reset
//   bus    sar_adc_if slave modport (en, A_in in; D_out, valid, busy, ovr out)
//
// Build option:
//   SAR_ADC_OVR_EN  when defined, an en arriving during a conversion (including
//                   the final decision edge) sets the sticky ovr flag; the next
//                   accepted en clears it. When undefined, ovr is tied low.
module sar_adc #(
   parameter real VREF  = 3.3,
   parameter int  NBITS = 8
) (
   input logic      clk,
   input logic      rst_n,
   sar_adc_if.slave bus
);

   typedef enum logic {
      IDLE,
      CONV
   } state_t;

   localparam real              TWO_N = real'(32'd1 << NBITS);
   localparam logic [NBITS-1:0] MSB   = {1'b1, {(NBITS-1){1'b0}}};

   state_t           state_q, state_d;
   logic [NBITS-1:0] trial_q, trial_d;
   logic [NBITS-1:0] mask_q, mask_d;
   logic [NBITS-1:0] code_q, code_d;
   logic [NBITS-1:0] decided;
   logic             valid_q, valid_d;
   real              hold_q, hold_d;
   real              threshold;

   // The bit under test is tracked as a one-hot mask rather than an index.
   // Each CONV edge compares the hold voltage with the voltage of the current
   // trial code, drops the tested bit if the input is below it, then moves the
   // mask one place down and sets that bit as the next trial. The conversion
   // ends on the edge where the mask sits on bit 0. Inputs below zero lose
   // every bit and inputs at or above the top threshold keep every bit, so the
   // result saturates without any explicit clamp.
   always_comb begin
      state_d   = state_q;
      trial_d   = trial_q;
      mask_d    = mask_q;
      code_d    = code_q;
      hold_d    = hold_q;
      valid_d   = 1'b0;
      decided   = trial_q;
      threshold = real'(trial_q) * VREF / TWO_N;

      case (state_q)
         IDLE: begin
            if (bus.en) begin
               hold_d  = bus.A_in;
               trial_d = MSB;
               mask_d  = MSB;
               state_d = CONV;
            end
         end
         CONV: begin
            if (hold_q < threshold) begin
               decided = trial_q & ~mask_q;
            end
            trial_d = decided | (mask_q >> 1);
            mask_d  = mask_q >> 1;
            if (mask_q[0]) begin
               code_d  = decided;
               valid_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register. Reset aborts any conversion in flight without a valid
   // strobe and returns the hold register to 0 V.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         trial_q <= '0;
         mask_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         hold_q  <= 0.0;
      end else begin
         state_q <= state_d;
         trial_q <= trial_d;
         mask_q  <= mask_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
      end
   end

`ifdef SAR_ADC_OVR_EN
   logic ovr_q;

   // An en seen while converting marks an overrun; an en seen while idle is
   // accepted as a new conversion and clears the flag on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_q <= 1'b0;
      end else if (bus.en) begin
         ovr_q <= (state_q == CONV);
      end
   end

   assign bus.ovr = ovr_q;
`else
   assign bus.ovr = 1'b0;
`endif

   assign bus.D_out = code_q;
   assign bus.valid = valid_q;
   assign bus.busy  = (state_q == CONV);

endmodule
